// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-collector pull-low enables.
// Optional watchdog: define PS2_TX_TIMEOUT_EN to abort a frame when the device stops clocking.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10000,
    parameter int unsigned RTS_CYCLES     = 50,
    parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam int unsigned DLY_MAX = (INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES;
    localparam int unsigned DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX) : 1;
    localparam logic [DLY_W-1:0] INH_LAST = DLY_W'(INHIBIT_CYCLES - 1);
    localparam logic [DLY_W-1:0] RTS_LAST = DLY_W'(RTS_CYCLES - 1);

    if (INHIBIT_CYCLES == 0 || RTS_CYCLES == 0) begin : g_bad_delay
        $error("ps2_host_tx: INHIBIT_CYCLES and RTS_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES == 0 || TIMEOUT_CYCLES > 2097152) begin : g_bad_timeout
        $error("ps2_host_tx: TIMEOUT_CYCLES must fit the 21-bit watchdog");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           state_q;
    logic             clk_s1_q, clk_s2_q, clk_prev_q;
    logic             data_s1_q, data_s2_q;
    logic [9:0]       frame_q, frame_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [3:0]       bitcnt_q;
    logic             nack_q;
    logic             tx_ready_q, busy_q, done_q, ack_err_q;
    logic             clk_oe_q, data_oe_q;
    logic             ps2_fall, line_idle, wd_hit;

    // A fall is only meaningful once the device owns the clock (SEND/ACK/WAIT_IDLE).
    assign ps2_fall  = clk_prev_q & ~clk_s2_q;
    assign line_idle = clk_s2_q & data_s2_q;

    always_comb begin
        frame_d = {1'b1, ~^tx_data, tx_data};
        dly_d   = dly_q + DLY_W'(1);
    end

`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [20:0] WD_LAST = 21'(TIMEOUT_CYCLES - 1);
    logic [20:0] wd_q;
    logic        wd_active;

    assign wd_active = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    assign wd_hit    = wd_active && !ps2_fall && (wd_q == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst || !wd_active || ps2_fall) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 21'd1;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        clk_s1_q   <= ps2_clk_i;
        clk_s2_q   <= clk_s1_q;
        clk_prev_q <= clk_s2_q;
        data_s1_q  <= ps2_data_i;
        data_s2_q  <= data_s1_q;

        if (rst) begin
            state_q    <= S_IDLE;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            nack_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wd_hit) begin
                state_q    <= S_IDLE;
                tx_ready_q <= 1'b1;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                ack_err_q  <= 1'b1;
                clk_oe_q   <= 1'b0;
                data_oe_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (tx_valid) begin
                            frame_q    <= frame_d;
                            dly_q      <= '0;
                            bitcnt_q   <= '0;
                            nack_q     <= 1'b0;
                            ack_err_q  <= 1'b0;
                            tx_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            clk_oe_q   <= 1'b1;
                            data_oe_q  <= 1'b0;
                            state_q    <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (dly_q == INH_LAST) begin
                            dly_q     <= '0;
                            data_oe_q <= 1'b1;
                            state_q   <= S_RTS;
                        end else begin
                            dly_q <= dly_d;
                        end
                    end
                    S_RTS: begin
                        // Data stays low as the start bit once the clock is handed to the device.
                        if (dly_q == RTS_LAST) begin
                            clk_oe_q <= 1'b0;
                            state_q  <= S_SEND;
                        end else begin
                            dly_q <= dly_d;
                        end
                    end
                    S_SEND: begin
                        if (ps2_fall) begin
                            data_oe_q <= ~frame_q[0];
                            frame_q   <= {1'b1, frame_q[9:1]};
                            bitcnt_q  <= bitcnt_q + 4'd1;
                            if (bitcnt_q == 4'd9) begin
                                state_q <= S_ACK;
                            end
                        end
                    end
                    S_ACK: begin
                        if (ps2_fall) begin
                            nack_q  <= data_s2_q;
                            state_q <= S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (line_idle) begin
                            done_q     <= 1'b1;
                            ack_err_q  <= nack_q;
                            tx_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q    <= S_IDLE;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        clk_oe_q   <= 1'b0;
                        data_oe_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = tx_ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames in over wired-AND lines.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH = 100;
    localparam int RTS = 10;
    localparam int TMO = 1000;
    localparam int H   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err;
    logic       m_clk = 1'b1;
    logic       m_data = 1'b1;
    logic       ps2_clk_line, ps2_data_line;

    int   n_tests = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    logic last_ack_err = 1'b0;

    assign ps2_clk_line  = !ps2_clk_oe && m_clk;
    assign ps2_data_line = !ps2_data_oe && m_data;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .RTS_CYCLES    (RTS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .ps2_clk_i  (ps2_clk_line),
        .ps2_data_i (ps2_data_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) begin
            done_cnt     <= done_cnt + 1;
            last_ack_err <= ack_err;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: observed sim time %0t, required finish before it", $time);
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clk);
        while (!tx_ready && t < 5000) begin
            @(negedge clk);
            t++;
        end
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device side: H-cycle clock phases, data read on each rising edge, optional ACK on clock 11.
    task automatic device_rx(input int nclk, input bit do_ack, output logic [9:0] bits);
        int t;
        bits = '0;
        t = 0;
        while (!(!ps2_clk_oe && ps2_data_oe) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("rts_reached", 32'(t < 1000), 32'd1);
        repeat (5) @(negedge clk);
        check("start_bit", 32'(ps2_data_line), 32'd0);
        for (int k = 1; k <= nclk; k++) begin
            m_clk = 1'b0;
            repeat (H) @(negedge clk);
            m_clk = 1'b1;
            if (k <= 10) bits[k-1] = ps2_data_line;
            if (k == 10 && do_ack) begin
                repeat (H / 2) @(negedge clk);
                m_data = 1'b0;
                repeat (H - H / 2) @(negedge clk);
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        m_data = 1'b1;
    endtask

    task automatic wait_done(input int prev, input int budget, output int waited);
        waited = 0;
        while (done_cnt == prev && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check("done_seen", 32'(done_cnt != prev), 32'd1);
    endtask

    initial begin
        logic [9:0] bits;
        logic [7:0] t2_byte [2];
        logic [9:0] t2_frame [2];
        int prev, w, cnt;

        t2_byte[0] = 8'h01; t2_frame[0] = 10'h201;
        t2_byte[1] = 8'h00; t2_frame[1] = 10'h300;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ack_err", 32'(ack_err), 32'd0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // T1: 0xED, ACKed
        prev = done_cnt;
        send_byte(8'hED);
        check("t1_tx_ready_low", 32'(tx_ready), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_inhibit_clk_oe", 32'(ps2_clk_oe), 32'd1);
        check("t1_inhibit_data_oe", 32'(ps2_data_oe), 32'd0);
        cnt = 0;
        while (!ps2_data_oe && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("t1_inhibit_len", 32'(cnt), 32'(INH));
        check("t1_rts_clk_oe", 32'(ps2_clk_oe), 32'd1);
        cnt = 0;
        while (ps2_clk_oe && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("t1_rts_len", 32'(cnt), 32'(RTS));
        device_rx(11, 1'b1, bits);
        check("t1_frame", 32'(bits), 32'h3ED);
        wait_done(prev, 200, w);
        check("t1_ack_err", 32'(last_ack_err), 32'd0);
        check("t1_done_pulse_width", 32'(done), 32'd0);
        check("t1_done_count", 32'(done_cnt - prev), 32'd1);
        check("t1_tx_ready_back", 32'(tx_ready), 32'd1);
        check("t1_busy_clear", 32'(busy), 32'd0);

        // T2: parity 0 and parity 1 cases
        for (int i = 0; i < 2; i++) begin
            prev = done_cnt;
            send_byte(t2_byte[i]);
            device_rx(11, 1'b1, bits);
            check("t2_frame", 32'(bits), 32'(t2_frame[i]));
            wait_done(prev, 200, w);
            check("t2_ack_err", 32'(last_ack_err), 32'd0);
        end

        // T3: device never ACKs
        prev = done_cnt;
        send_byte(8'hFF);
        device_rx(11, 1'b0, bits);
        check("t3_frame", 32'(bits), 32'h3FF);
        wait_done(prev, 200, w);
        check("t3_ack_err_at_done", 32'(last_ack_err), 32'd1);
        check("t3_tx_ready", 32'(tx_ready), 32'd1);
        repeat (10) @(negedge clk);
        check("t3_ack_err_holds", 32'(ack_err), 32'd1);

        // T4: request held while busy is not queued
        prev = done_cnt;
        send_byte(8'hF4);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        device_rx(11, 1'b1, bits);
        check("t4_first_frame", 32'(bits), 32'h2F4);
        wait_done(prev, 200, w);
        check("t4_first_ack_err", 32'(last_ack_err), 32'd0);
        cnt = 0;
        while (!busy && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("t4_second_accept", 32'(busy), 32'd1);
        tx_valid = 1'b0;
        prev = done_cnt;
        device_rx(11, 1'b1, bits);
        check("t4_second_frame", 32'(bits), 32'h3AA);
        wait_done(prev, 200, w);
        check("t4_second_ack_err", 32'(last_ack_err), 32'd0);

        // T5: reset while bit 4 (a zero) is on the line
        prev = done_cnt;
        send_byte(8'hEF);
        device_rx(5, 1'b0, bits);
        check("t5_bit4_driven", 32'(ps2_data_oe), 32'd1);
        check("t5_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t5_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("t5_data_oe", 32'(ps2_data_oe), 32'd0);
        check("t5_tx_ready", 32'(tx_ready), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("t5_no_done", 32'(done_cnt - prev), 32'd0);
        prev = done_cnt;
        send_byte(8'h01);
        device_rx(11, 1'b1, bits);
        check("t5_recovery_frame", 32'(bits), 32'h201);
        wait_done(prev, 200, w);

`ifdef PS2_TX_TIMEOUT_EN
        // T6: device stops clocking after bit 3
        prev = done_cnt;
        send_byte(8'hF4);
        device_rx(4, 1'b0, bits);
        wait_done(prev, 1200, w);
        check("t6_timeout_window", 32'((w + 2 * H) >= 995 && (w + 2 * H) <= 1015), 32'd1);
        check("t6_ack_err", 32'(last_ack_err), 32'd1);
        check("t6_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("t6_data_oe", 32'(ps2_data_oe), 32'd0);
        check("t6_tx_ready", 32'(tx_ready), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
